// File: rtl/dp_ram.sv
// Dual-port word RAM: instruction read port plus byte/half/word data port.
// Ports: clk, rst_n, i_req/i_addr -> i_data/i_valid,
//   d_req/d_we/d_size/d_addr/d_in -> d_out_data/d_valid/d_err.
// Macro DP_RAM_WR_FWD_EN: same-cycle read of a word being stored
//   returns the merged post-write word instead of the old word.
module dp_ram #(
    parameter int ADDR_W    = 14,
    parameter int INIT_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_data,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_in,
    output logic [31:0]       d_out_data,
    output logic              d_valid,
    output logic              d_err
);

    localparam int WA    = ADDR_W - 2;
    localparam int DEPTH = 1 << WA;
    localparam logic [31:0] INIT_VAL = (INIT_ZERO != 0) ? 32'h0 : 'x;

    logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};

    logic [WA-1:0] iw;
    logic [WA-1:0] dw;
    logic [1:0]    off;
    logic          unused_ia;

    assign iw        = i_addr[ADDR_W-1:2];
    assign dw        = d_addr[ADDR_W-1:2];
    assign off       = d_addr[1:0];
    assign unused_ia = ^i_addr[1:0];

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        size_ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic [31:0] sh;
    logic [31:0] load;
    logic        err;
    logic        wr_en;
    logic [31:0] i_word;
    logic [31:0] d_out_d;

    // Bit 2 of funct3 only selects zero-extension, so B/BU and H/HU
    // share a decode; stores with bit 2 set are rejected below.
    assign is_b = (d_size[1:0] == 2'b00);
    assign is_h = (d_size[1:0] == 2'b01);
    assign is_w = (d_size == 3'b010);

    assign rd_word = mem_q[dw];
    assign sh      = rd_word >> {off, 3'b000};

    always_comb begin
        size_ok = 1'b0;
        be      = 4'h0;
        wdata   = d_in;
        load    = '0;
        unique case (1'b1)
            is_w: begin
                size_ok = (off == 2'b00);
                be      = 4'hf;
                load    = rd_word;
            end
            is_h: begin
                size_ok = ~off[0];
                be      = off[1] ? 4'hc : 4'h3;
                wdata   = {2{d_in[15:0]}};
                load    = {{16{sh[15] & ~d_size[2]}}, sh[15:0]};
            end
            is_b: begin
                size_ok = 1'b1;
                be      = 4'b0001 << off;
                wdata   = {4{d_in[7:0]}};
                load    = {{24{sh[7] & ~d_size[2]}}, sh[7:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    assign err   = d_req & (~size_ok | (d_we & d_size[2]));
    // rst_n gate keeps a store presented during reset from landing.
    assign wr_en = d_req & d_we & ~err & rst_n;

    assign d_out_d = (d_req & ~d_we & ~err) ? load : '0;

`ifdef DP_RAM_WR_FWD_EN
    assign i_word = (wr_en && iw == dw) ? merged : mem_q[iw];
`else
    assign i_word = mem_q[iw];
`endif

    // Memory array carries no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[dw] <= merged;
    end

    logic [31:0] i_data_q;
    logic        i_valid_q;
    logic [31:0] d_out_q;
    logic        d_valid_q;
    logic        d_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_data_q  <= '0;
            i_valid_q <= 1'b0;
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            i_valid_q <= i_req;
            if (i_req) i_data_q <= i_word;
            d_valid_q <= d_req;
            d_err_q   <= err;
            d_out_q   <= d_out_d;
        end
    end

    assign i_data     = i_data_q;
    assign i_valid    = i_valid_q;
    assign d_out_data = d_out_q;
    assign d_valid    = d_valid_q;
    assign d_err      = d_err_q;

endmodule
